// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared constants, id-width helper and tag type for the adder arbiter.
package add_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int ADD_LAT_DEF = 1;
  localparam int ID_MAX_W = 3;
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/add_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible at or after ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW:0] s;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    s = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      if (!any_o && elig_i[s[IW-1:0]]) begin
        any_o = 1'b1;
        grant_o[s[IW-1:0]] = 1'b1;
        idx_o = s[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one fixed-latency adder among N_REQ requesters,
// with a tag pipeline routing each sum back to its owner's result register.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW = DW_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DW-1:0]       req_a,
  input  logic [N_REQ*DW-1:0]       req_b,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [N_REQ*(DW+1)-1:0]   rsp_c,
  output logic [DW-1:0]             add_a,
  output logic [DW-1:0]             add_b,
  output logic                      add_valid_in,
  input  logic [DW:0]               add_c,
  input  logic                      add_valid_out,
  output logic                      proto_err
);
  localparam int IW = idw(N_REQ);
  localparam int CW = DW + 1;
  logic [IW-1:0] ptr_q, ptr_d, gnt_idx;
  logic [N_REQ-1:0] inflight_q, inflight_d, rsp_valid_q, rsp_valid_d, elig, gnt, cap;
  logic [N_REQ*CW-1:0] rsp_c_q;
  tag_t tag_q [ADD_LAT];
  tag_t tag_in, tag_out;
  logic [2:0] win_q;
  logic gnt_any, proto_err_q, proto_err_d, mismatch;
  // Grants are held off while reset is asserted so outputs show their reset values.
  assign elig = req_valid & ~(inflight_q | rsp_valid_q) & {N_REQ{rst_n}};
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .grant_o(gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );
  always_comb begin
    req_ready = gnt;
    add_valid_in = gnt_any;
    add_a = gnt_any ? req_a[int'(gnt_idx)*DW +: DW] : '0;
    add_b = gnt_any ? req_b[int'(gnt_idx)*DW +: DW] : '0;
    tag_in = gnt_any ? {1'b1, ID_MAX_W'(gnt_idx)} : '0;
    tag_out = tag_q[ADD_LAT-1];
    cap = tag_out.valid ? (N_REQ'(1) << tag_out.id) : '0;
    ptr_d = gnt_any ? ((int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    inflight_d = (inflight_q | gnt) & ~cap;
    rsp_valid_d = (rsp_valid_q & ~rsp_ready) | cap;
    // A stray adder strobe right after reset belongs to a discarded operation.
    mismatch = (add_valid_out != tag_out.valid) & ~(|win_q & ~tag_out.valid);
    proto_err_d = proto_err_q | mismatch;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      inflight_q <= '0;
      rsp_valid_q <= '0;
      rsp_c_q <= '0;
      proto_err_q <= 1'b0;
      win_q <= 3'(ADD_LAT);
      for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      inflight_q <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      proto_err_q <= proto_err_d;
      win_q <= win_q - {2'b0, |win_q};
      tag_q[0] <= tag_in;
      for (int k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
      if (tag_out.valid) rsp_c_q[int'(tag_out.id)*CW +: CW] <= add_c;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_c = rsp_c_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: random and directed stimulus against a queue-based reference model,
// with a latency-LAT adder model that can inject spurious result strobes.
module tb_add_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int LAT = 1;
  localparam int CW = DW + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic [N*CW-1:0] rsp_c;
  logic [DW-1:0] add_a, add_b;
  logic [DW:0] add_c;
  logic add_valid_in, add_valid_out, proto_err;
  logic spur = 1'b0;
  logic [LAT-1:0] av_s = '0;
  logic [DW:0] ac_s [LAT];
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  add_arbiter #(.N_REQ(N), .DW(DW), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .add_a(add_a), .add_b(add_b), .add_valid_in(add_valid_in),
    .add_c(add_c), .add_valid_out(add_valid_out), .proto_err(proto_err)
  );
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      av_s[k] <= av_s[k-1];
      ac_s[k] <= ac_s[k-1];
    end
    av_s[0] <= add_valid_in;
    ac_s[0] <= {1'b0, add_a} + {1'b0, add_b};
  end
  assign add_valid_out = av_s[LAT-1] | spur;
  assign add_c = ac_s[LAT-1];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  typedef struct {
    int due;
    int id;
    logic [DW:0] s;
  } pend_t;
  pend_t pq[$];
  int ptr_m = 0, cyc = 0, since_rst = 0, w, j;
  bit inflight_m [N], rspv_m [N];
  bit perr_m = 1'b0, tagv;
  logic [DW:0] rspc_m [N];
  logic [N*CW-1:0] exp_c;
  logic [N-1:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outs", {req_ready, add_valid_in, add_a, add_b, rsp_valid, proto_err}, '0);
      chk("rst_rsp_c", rsp_c, '0);
      ptr_m = 0;
      perr_m = 1'b0;
      since_rst = 0;
      pq.delete();
      for (int i = 0; i < N; i++) begin
        inflight_m[i] = 1'b0;
        rspv_m[i] = 1'b0;
        rspc_m[i] = '0;
      end
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (ptr_m + k) % N;
        if (w < 0 && req_valid[j] && !inflight_m[j] && !rspv_m[j]) w = j;
      end
      if (w >= 0)
        chk("grant", {req_ready, add_valid_in, add_a, add_b},
            {N'(1) << w, 1'b1, req_a[w*DW +: DW], req_b[w*DW +: DW]});
      else
        chk("grant", {req_ready, add_valid_in, add_a, add_b}, '0);
      for (int i = 0; i < N; i++) begin
        exp_v[i] = rspv_m[i];
        exp_c[i*CW +: CW] = rspc_m[i];
      end
      chk("rsp_valid", rsp_valid, exp_v);
      chk("rsp_c", rsp_c, exp_c);
      chk("proto_err", proto_err, perr_m);
      tagv = pq.size() > 0 && pq[0].due == cyc;
      if (add_valid_out !== tagv && !(since_rst < LAT && !tagv)) perr_m = 1'b1;
      for (int i = 0; i < N; i++) if (rspv_m[i] && rsp_ready[i]) rspv_m[i] = 1'b0;
      if (tagv) begin
        rspc_m[pq[0].id] = pq[0].s;
        rspv_m[pq[0].id] = 1'b1;
        inflight_m[pq[0].id] = 1'b0;
        void'(pq.pop_front());
      end
      if (w >= 0) begin
        inflight_m[w] = 1'b1;
        pq.push_back('{cyc + LAT, w, {1'b0, req_a[w*DW +: DW]} + {1'b0, req_b[w*DW +: DW]}});
        ptr_m = (w + 1) % N;
      end
      since_rst++;
    end
    cyc++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    spur = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask
  int g2, nv, dv, dr;
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    req_valid = 4'b0001;
    req_a[DW-1:0] = 8'hFF;
    req_b[DW-1:0] = 8'h01;
    @(negedge clk);
    chk("t1_grant", {req_ready, add_valid_in, add_a, add_b}, {4'b0001, 1'b1, 8'hFF, 8'h01});
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_pending", rsp_valid, 4'b0000);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_c", rsp_c[CW-1:0], 9'h100);
    chk("t1_perr", proto_err, 0);
    tick();
    do_reset();
    req_valid = '1;
    rsp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      req_a = $urandom();
      req_b = $urandom();
      @(negedge clk);
      chk("rr_order", {req_ready, add_valid_in}, {N'(1) << (c % N), 1'b1});
      tick();
    end
    do_reset();
    req_valid = '1;
    rsp_ready = 4'b1011;
    g2 = 0;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      req_a = $urandom();
      req_b = $urandom();
      req_a[2*DW +: DW] = 8'h80;
      req_b[2*DW +: DW] = 8'h90;
      @(negedge clk);
      g2 += int'(req_ready[2]);
      nv += int'(add_valid_in);
      tick();
    end
    chk("hold_grants2", g2, 1);
    chk("hold_issue", nv, 12);
    chk("hold_rsp_v2", rsp_valid[2], 1);
    chk("hold_rsp_c2", rsp_c[2*CW +: CW], 9'h110);
    do_reset();
    req_valid = 4'b0010;
    repeat (4) tick();
    rsp_ready = 4'b0010;
    @(negedge clk);
    chk("same_cycle_nogrant", {req_ready, rsp_valid}, {4'b0000, 4'b0010});
    tick();
    rsp_ready = '0;
    @(negedge clk);
    chk("regrant", req_ready, 4'b0010);
    tick();
    do_reset();
    req_valid = '1;
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {req_ready, add_valid_in, rsp_valid, proto_err, rsp_c}, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    req_valid = 4'b1100;
    spur = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0100);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("post_rst_quiet", {rsp_valid, proto_err}, '0);
    tick();
    for (int b = 0; b < 15; b++) begin
      dv = $urandom_range(10, 100);
      dr = $urandom_range(10, 100);
      repeat (200) begin
        for (int i = 0; i < N; i++) begin
          req_valid[i] = $urandom_range(0, 99) < dv;
          rsp_ready[i] = $urandom_range(0, 99) < dr;
        end
        req_a = $urandom();
        req_b = $urandom();
        tick();
      end
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) tick();
    spur = 1'b1;
    @(negedge clk);
    chk("spur_before", proto_err, 0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_perr", {proto_err, rsp_valid}, {1'b1, 4'b0000});
    repeat (5) tick();
    chk("perr_sticky", {proto_err, rsp_valid}, {1'b1, 4'b0000});
    do_reset();
    @(negedge clk);
    chk("perr_cleared", proto_err, 0);
    tick();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin scheduler that shares one fixed-latency 8-bit adder among N_REQ requesters. Each requester issues an operand pair over a valid/ready handshake. The block routes the winner's operands to the adder and tracks the requester ID through the adder latency. It returns the 9-bit sum to the owning requester over a valid/ready response port. It sits between the client blocks and the single adder instance.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DW, 8: operand width; sum width is DW+1
- ADD_LAT, 1: adder latency in cycles, 1..4; must match the attached adder
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester operand request
- req_ready  out  N_REQ  per-requester grant; one-hot or zero
- req_a  in  N_REQ*DW  packed operand A; slot i at [i*DW +: DW]
- req_b  in  N_REQ*DW  packed operand B
- rsp_valid  out  N_REQ  per-requester result available
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_c  out  N_REQ*(DW+1)  packed per-requester result registers
- add_a, add_b  out  DW  operands to adder
- add_valid_in  out  1  adder issue strobe
- add_c  in  DW+1  adder sum
- add_valid_out  in  1  adder result strobe
- proto_err  out  1  sticky: add_valid_out disagrees with the tag pipeline

## Operation
- busy[i] = inflight[i] | rsp_valid[i], computed from registered state only.
- eligible[i] = req_valid[i] & ~busy[i].
- Round-robin pick among eligible requesters:
  - Search starts at ptr and wraps modulo N_REQ.
  - On a grant, ptr <= winner+1 (wraps).
  - On no grant, ptr holds.
- Grant is combinational in the same cycle:
  - req_ready[winner]=1; all other bits 0.
  - add_valid_in=1; add_a/add_b = winner's operands.
  - With no grant, add_valid_in=0 and add_a/add_b=0.
- req_ready may depend on req_valid. A request is transferred only on req_valid&req_ready.
- On a grant, inflight[winner] is set, and {1, winner} enters a tag shift register of depth ADD_LAT.
- At the tag-pipeline output with tag_valid=1:
  - add_c is written to rsp_c slot tag_id.
  - rsp_valid[tag_id] is set; inflight[tag_id] is cleared.
- rsp_valid[i] clears on rsp_valid[i]&rsp_ready[i]. rsp_c slot i holds its value until the next write.
- Each requester has at most one operation outstanding, so result slots cannot overflow.
- proto_err sets when add_valid_out != tag_valid at the pipeline output. It clears only on reset. Result capture follows the tag pipeline, not add_valid_out.
- Sum is passed through unmodified, full DW+1 bits, no truncation.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_c=0.
  - add_valid_in=0, add_a=0, add_b=0.
  - proto_err=0, ptr=0, inflight=0, tag pipeline empty.
- Grant in cycle t → add_valid_out expected in cycle t+ADD_LAT → rsp_valid high from cycle t+ADD_LAT+1.
- Response handshake in cycle r → busy clears at cycle r+1. That requester can be re-granted no earlier than r+1, never in cycle r.
- Single requester with rsp_ready held high: one operation per ADD_LAT+2 cycles.
- With ≥ ADD_LAT+2 active requesters, one issue per cycle.
- Result capture and a new grant to a different requester in the same cycle are independent and both occur.
- An asserted reset mid-operation discards in-flight tags and pending results. The adder's late add_valid_out after reset is ignored and does not set proto_err; tag_valid=0 is treated as don't-care for one ADD_LAT window after reset.

## Structure
- Package add_arb_pkg holds:
  - default constants N_REQ_DEF=4, DW_DEF=8, ADD_LAT_DEF=1;
  - ID width function idw(n) = max(1, $clog2(n));
  - a typedef for the tag struct {valid, id}.
- Sub-module rr_pick: purely combinational round-robin picker (eligible vector + ptr → one-hot grant + encoded index).
- All state (ptr, inflight, tag pipeline, rsp registers, proto_err) lives in add_arbiter.

## Test plan
- Reset, then requester 0 only, a=8'hFF b=8'h01, ADD_LAT=1 → grant at cycle 0; rsp_valid[0] high at cycle 2 with rsp_c[0]=9'h100; proto_err=0.
- All 4 requesters valid continuously with rsp_ready=all-ones → grant order 0,1,2,3,0,…; one add_valid_in per cycle; each result matches its own a+b.
- Requester 2 with rsp_ready[2]=0 for 10 cycles → rsp_valid[2] and rsp_c[2] held stable; requester 2 not re-granted; others continue round-robin.
- Requester 1 response handshake in the same cycle req_valid[1]=1 → no grant to 1 that cycle; granted next cycle if ptr order allows.
- Reset asserted while 3 operations are in flight → all outputs return to reset values; no rsp_valid after release; first post-reset grant goes to the lowest-index valid requester.
- Adder model injects a spurious add_valid_out with an empty pipeline → proto_err=1 and stays 1 until reset; no rsp_valid change.
